// File: rtl/cascade_pkg.sv
// Shared types and defaults for the mm:ss cascade controller.
package cascade_pkg;
  localparam int DIGIT_W  = 4;
  localparam int MAX0_DEF = 9;
  localparam int MAX1_DEF = 5;
  localparam int MAX2_DEF = 9;
  localparam int MAX3_DEF = 5;

  typedef enum logic [1:0] {
    CLR   = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;
endpackage

// File: rtl/cascade_ctrl_tick.sv
// Prescaler: tick every DIV cycles while run is high; phase holds when run is low.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic zero,
  output logic tick
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (zero)
      pre_d = '0;
    else if (run)
      pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign tick = run && (pre_q == LAST);
endmodule

// File: rtl/cascade_ctrl.sv
// Run/pause/clear control and zero-latency carry chain for four external digit counters.
module cascade_ctrl
  import cascade_pkg::*;
#(
  parameter int DIV  = 4,
  parameter int MAX0 = MAX0_DEF,
  parameter int MAX1 = MAX1_DEF,
  parameter int MAX2 = MAX2_DEF,
  parameter int MAX3 = MAX3_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] cnt0,
  input  logic [DIGIT_W-1:0] cnt1,
  input  logic [DIGIT_W-1:0] cnt2,
  input  logic [DIGIT_W-1:0] cnt3,
  output logic [3:0]         en,
  output logic               clr,
  output logic               running,
  output logic               ovf
);
  state_e state_q, state_d;
  logic   ovf_q, ovf_d;
  logic   tick;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = CLR;
    end else begin
      case (state_q)
        CLR:     state_d = IDLE;
        IDLE:    if (start_stop) state_d = RUN;
        RUN:     if (start_stop) state_d = PAUSE;
        PAUSE:   if (start_stop) state_d = RUN;
        default: state_d = CLR;
      endcase
    end
  end

  assign clr     = (state_q == CLR);
  assign running = (state_q == RUN);

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (running),
    .zero (clr),
    .tick (tick)
  );

  // tick is already gated by RUN, so every en bit is zero outside RUN.
  assign en[0] = tick;
  assign en[1] = en[0] && (cnt0 == DIGIT_W'(MAX0));
  assign en[2] = en[1] && (cnt1 == DIGIT_W'(MAX1));
  assign en[3] = en[2] && (cnt2 == DIGIT_W'(MAX2));

  always_comb begin
    ovf_d = ovf_q;
    if (clr)
      ovf_d = 1'b0;
    else if (en[3] && (cnt3 == DIGIT_W'(MAX3)))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_cascade_ctrl.sv
// Self-checking bench for cascade_ctrl with a behavioural model of the four digit counters.
module tb_cascade_ctrl;
  import cascade_pkg::*;

  typedef struct {
    logic        clr;
    logic        running;
    logic [3:0]  en;
    logic        ovf;
    logic [15:0] dig;
  } exp_t;

  typedef struct {
    logic r;
    logic s;
    logic c;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  cnt0 = 4'd0, cnt1 = 4'd0, cnt2 = 4'd0, cnt3 = 4'd0;
  logic [3:0]  en;
  logic        clr, running, ovf;
  logic        ld_req = 1'b0;
  logic [15:0] ld_val = 16'h0;
  int          total = 0;
  int          bad = 0;
  int          step = 0;
  exp_t        sb[$];
  vec_t        tbl[15];

  always #5 clk = ~clk;

  cascade_ctrl #(.DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt3       (cnt3),
    .en         (en),
    .clr        (clr),
    .running    (running),
    .ovf        (ovf)
  );

  function automatic logic [3:0] nxt(input logic [3:0] v, input int mx);
    return (v == 4'(mx)) ? 4'd0 : v + 4'd1;
  endfunction

  // Digit counters: load hook for corner setups, then clr, then per-digit enable.
  always @(posedge clk) begin
    if (ld_req) begin
      {cnt3, cnt2, cnt1, cnt0} <= ld_val;
    end else if (clr) begin
      {cnt3, cnt2, cnt1, cnt0} <= 16'h0;
    end else begin
      if (en[0]) cnt0 <= nxt(cnt0, MAX0_DEF);
      if (en[1]) cnt1 <= nxt(cnt1, MAX1_DEF);
      if (en[2]) cnt2 <= nxt(cnt2, MAX2_DEF);
      if (en[3]) cnt3 <= nxt(cnt3, MAX3_DEF);
    end
  end

  function automatic exp_t mk(input logic c, input logic r, input logic [3:0] e,
                              input logic o, input logic [15:0] d);
    exp_t x;
    x.clr = c; x.running = r; x.en = e; x.ovf = o; x.dig = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL step%0d %s: got %h want %h", step, nm, act, want);
    end
  endtask

  // One cycle: drive at the falling edge, queue the expectation, compare mid-cycle.
  task automatic cyc(input logic r, input logic s, input logic c, input logic l,
                     input logic [15:0] lv, input exp_t e);
    exp_t w;
    @(negedge clk);
    rst = r; start_stop = s; clear = c; ld_req = l; ld_val = lv;
    sb.push_back(e);
    #1;
    w = sb.pop_front();
    chk("clr",     16'(clr),     16'(w.clr));
    chk("running", 16'(running), 16'(w.running));
    chk("en",      16'(en),      16'(w.en));
    chk("ovf",     16'(ovf),     16'(w.ovf));
    chk("digits",  {cnt3, cnt2, cnt1, cnt0}, w.dig);
    step++;
  endtask

  initial begin
    // Reset, idle, start and the first two ticks.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h1, 1'b0, 16'h0000)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0001)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0001)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0001)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h1, 1'b0, 16'h0001)};
    tbl[14] = '{1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0002)};

    for (int i = 0; i < 15; i++)
      cyc(tbl[i].r, tbl[i].s, tbl[i].c, 1'b0, 16'h0, tbl[i].e);

    // Pause with the prescaler at 2; phase must survive 10 paused cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0002));
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0002));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0002));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0002));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h1, 1'b0, 16'h0002));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0003));

    // Clear, preload 0:3:5:9, run to a three-digit carry.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0003));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0003));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0359, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0359));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0359));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h7, 1'b0, 16'h0359));

    // Full rollover from 59:59, counting continues with ovf sticky.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0400));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h5959));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h5959));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'hF, 1'b0, 16'h5959));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b1, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h1, 1'b1, 16'h0000));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b1, 16'h0001));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b1, 1'b0, 4'h0, 1'b1, 16'h0001));

    // Clear and start_stop together in RUN: clear wins.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000));

    // Asynchronous reset mid-RUN drops the prescaler phase.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b1, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000));
    // start_stop on the tick cycle still lets that tick through.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b1, 4'h1, 1'b0, 16'h0000));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, mk(1'b0, 1'b0, 4'h0, 1'b0, 16'h0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
